// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit bus CPU core: opcodes, microstate encodings
// and the ALU mode selector.
package cpu_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDA = 8'h01;
    localparam logic [7:0] OP_LDB = 8'h02;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;
    localparam logic [7:0] OP_OUT = 8'h05;
    localparam logic [7:0] OP_STA = 8'h06;
    localparam logic [7:0] OP_JMP = 8'h07;
    localparam logic [7:0] OP_JEZ = 8'h08;
    localparam logic [7:0] OP_JNZ = 8'h09;
    localparam logic [7:0] OP_HLT = 8'h0A;

    localparam logic [3:0] ST_FETCH_PC   = 4'd0;
    localparam logic [3:0] ST_FETCH_INST = 4'd1;
    localparam logic [3:0] ST_LOAD_ADDR  = 4'd2;
    localparam logic [3:0] ST_RAM_A      = 4'd3;
    localparam logic [3:0] ST_RAM_B      = 4'd4;
    localparam logic [3:0] ST_ALU_OP     = 4'd5;
    localparam logic [3:0] ST_OUT_A      = 4'd6;
    localparam logic [3:0] ST_STORE_A    = 4'd7;
    localparam logic [3:0] ST_JUMP       = 4'd8;
    localparam logic [3:0] ST_HALT       = 4'd9;
    localparam logic [3:0] ST_NEXT       = 4'd10;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_mode_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit adder/subtractor. In subtract mode the carry output is
// the no-borrow flag; eq_zero reflects operand A, not the result.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0] rega,
    input  logic [7:0] regb,
    input  alu_mode_e  mode,
    output logic [7:0] result,
    output logic       cout,
    output logic       eq_zero
);

    logic [8:0] sum9;
    logic [7:0] diff;

    assign sum9 = {1'b0, rega} + {1'b0, regb};
    assign diff = rega - regb;

    always_comb begin
        result = sum9[7:0];
        cout   = sum9[8];
        if (mode == ALU_SUB) begin
            result = diff;
            cout   = (rega >= regb);
        end
    end

    assign eq_zero = (rega == 8'h00);

endmodule

// File: rtl/cpu_seq_core.sv
// Control-and-arithmetic core: program counter, ALU and microcode sequencer.
// The microstate is a pure function of (opcode, cycle); strobes follow from it.
module cpu_seq_core
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bus_in,
    input  logic [7:0] opcode,
    input  logic [7:0] rega,
    input  logic [7:0] regb,
    output logic [7:0] pc,
    output logic [7:0] alu_out,
    output logic       alu_cout,
    output logic       eq_zero,
    output logic [3:0] cycle,
    output logic [3:0] state,
    output logic       c_ai,
    output logic       c_bi,
    output logic       c_ii,
    output logic       c_mi,
    output logic       c_ao,
    output logic       c_co,
    output logic       c_eo,
    output logic       c_ro,
    output logic       c_ri,
    output logic       c_oi,
    output logic       c_halt
);

    logic [7:0] op_n;
    logic       jump_ok;
    logic       c_j;
    logic       pc_step;
    alu_mode_e  alu_mode;

    // Unknown opcodes are folded onto NOP so the sequencer sees a closed set.
    always_comb begin
        case (opcode)
            OP_NOP, OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_OUT,
            OP_STA, OP_JMP, OP_JEZ, OP_JNZ, OP_HLT: op_n = opcode;
            default:                                op_n = OP_NOP;
        endcase
    end

    always_comb begin
        state = ST_NEXT;
        if (cycle == 4'd0) begin
            state = ST_FETCH_PC;
        end else if (cycle == 4'd1) begin
            state = ST_FETCH_INST;
        end else begin
            case (op_n)
                OP_LDA: begin
                    case (cycle)
                        4'd2:    state = ST_FETCH_PC;
                        4'd3:    state = ST_LOAD_ADDR;
                        4'd4:    state = ST_RAM_A;
                        default: state = ST_NEXT;
                    endcase
                end
                OP_LDB: begin
                    case (cycle)
                        4'd2:    state = ST_FETCH_PC;
                        4'd3:    state = ST_LOAD_ADDR;
                        4'd4:    state = ST_RAM_B;
                        default: state = ST_NEXT;
                    endcase
                end
                OP_ADD, OP_SUB: begin
                    if (cycle == 4'd2) state = ST_ALU_OP;
                end
                OP_OUT: begin
                    if (cycle == 4'd2) state = ST_OUT_A;
                end
                OP_STA: begin
                    case (cycle)
                        4'd2:    state = ST_FETCH_PC;
                        4'd3:    state = ST_LOAD_ADDR;
                        4'd4:    state = ST_STORE_A;
                        default: state = ST_NEXT;
                    endcase
                end
                OP_JMP, OP_JEZ, OP_JNZ: begin
                    case (cycle)
                        4'd2:    state = ST_FETCH_PC;
                        4'd3:    state = ST_JUMP;
                        default: state = ST_NEXT;
                    endcase
                end
                OP_HLT: begin
                    if (cycle == 4'd2) state = ST_HALT;
                end
                default: state = ST_NEXT;
            endcase
        end
    end

    assign alu_mode = (op_n == OP_SUB) ? ALU_SUB : ALU_ADD;

    cpu_alu u_alu (
        .rega    (rega),
        .regb    (regb),
        .mode    (alu_mode),
        .result  (alu_out),
        .cout    (alu_cout),
        .eq_zero (eq_zero)
    );

    assign jump_ok = (op_n == OP_JMP)
                   | ((op_n == OP_JEZ) & eq_zero)
                   | ((op_n == OP_JNZ) & ~eq_zero);
    assign c_j     = (state == ST_JUMP) & jump_ok;

    assign c_ai   = (state == ST_RAM_A) | (state == ST_ALU_OP);
    assign c_ao   = (state == ST_OUT_A) | (state == ST_STORE_A);
    assign c_bi   = (state == ST_RAM_B);
    assign c_co   = (state == ST_FETCH_PC);
    assign c_eo   = (state == ST_ALU_OP);
    assign c_ii   = (state == ST_FETCH_INST);
    assign c_mi   = (state == ST_FETCH_PC) | (state == ST_LOAD_ADDR);
    assign c_oi   = (state == ST_OUT_A);
    assign c_ri   = (state == ST_STORE_A);
    assign c_halt = (state == ST_HALT);
    assign c_ro   = (state == ST_FETCH_INST) | (state == ST_LOAD_ADDR)
                  | (state == ST_RAM_A) | (state == ST_RAM_B) | c_j;

    assign pc_step = (state == ST_FETCH_INST) | (state == ST_LOAD_ADDR)
                   | (state == ST_JUMP);

    // A failed conditional jump still steps the PC, skipping its operand byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle <= 4'd0;
            pc    <= RESET_PC;
        end else begin
            case (state)
                ST_NEXT: cycle <= 4'd0;
                ST_HALT: cycle <= cycle;
                default: cycle <= cycle + 4'd1;
            endcase
            if (pc_step) begin
                pc <= c_j ? bus_in : pc + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_seq_core.sv
// Bench for cpu_seq_core: a driver issues instructions and queues the expected
// per-cycle observation; a negedge monitor pops and compares.
module tb_cpu_seq_core;
    import cpu_pkg::*;

    localparam int W = 37;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic [7:0] opcode = 8'h00;
    logic [7:0] rega = 8'h00;
    logic [7:0] regb = 8'h00;
    logic [7:0] pc, alu_out;
    logic       alu_cout, eq_zero;
    logic [3:0] cycle, state;
    logic       c_ai, c_bi, c_ii, c_mi, c_ao, c_co, c_eo, c_ro, c_ri, c_oi, c_halt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];
    bit           mon_en = 1'b0;
    int           steps[$];
    logic [7:0]   pc_m = 8'h00;
    logic [W-1:0] obs;

    cpu_seq_core #(.RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .opcode(opcode),
        .rega(rega), .regb(regb), .pc(pc), .alu_out(alu_out),
        .alu_cout(alu_cout), .eq_zero(eq_zero), .cycle(cycle), .state(state),
        .c_ai(c_ai), .c_bi(c_bi), .c_ii(c_ii), .c_mi(c_mi), .c_ao(c_ao),
        .c_co(c_co), .c_eo(c_eo), .c_ro(c_ro), .c_ri(c_ri), .c_oi(c_oi),
        .c_halt(c_halt)
    );

    always #5 clk = ~clk;

    assign obs = {state, cycle, pc, c_ai, c_bi, c_ii, c_mi, c_ao, c_co, c_eo,
                  c_ro, c_ri, c_oi, c_halt, alu_out, alu_cout, eq_zero};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Strobe set per microstate, bit order {ai,bi,ii,mi,ao,co,eo,ro,ri,oi,halt}.
    function automatic logic [10:0] strobes_of(input logic [3:0] st, input bit jok);
        case (st)
            ST_FETCH_PC:   return 11'b000_1010_0000;
            ST_FETCH_INST: return 11'b001_0000_1000;
            ST_LOAD_ADDR:  return 11'b000_1000_1000;
            ST_RAM_A:      return 11'b100_0000_1000;
            ST_RAM_B:      return 11'b010_0000_1000;
            ST_ALU_OP:     return 11'b100_0001_0000;
            ST_OUT_A:      return 11'b000_0100_0010;
            ST_STORE_A:    return 11'b000_0100_0100;
            ST_JUMP:       return jok ? 11'b000_0000_1000 : 11'b000_0000_0000;
            ST_HALT:       return 11'b000_0000_0001;
            default:       return 11'b000_0000_0000;
        endcase
    endfunction

    task automatic build_steps(input logic [7:0] op);
        steps = {int'(ST_FETCH_PC), int'(ST_FETCH_INST)};
        case (op)
            OP_LDA: steps = {steps, int'(ST_FETCH_PC), int'(ST_LOAD_ADDR), int'(ST_RAM_A), int'(ST_NEXT)};
            OP_LDB: steps = {steps, int'(ST_FETCH_PC), int'(ST_LOAD_ADDR), int'(ST_RAM_B), int'(ST_NEXT)};
            OP_ADD, OP_SUB: steps = {steps, int'(ST_ALU_OP), int'(ST_NEXT)};
            OP_OUT: steps = {steps, int'(ST_OUT_A), int'(ST_NEXT)};
            OP_STA: steps = {steps, int'(ST_FETCH_PC), int'(ST_LOAD_ADDR), int'(ST_STORE_A), int'(ST_NEXT)};
            OP_JMP, OP_JEZ, OP_JNZ: steps = {steps, int'(ST_FETCH_PC), int'(ST_JUMP), int'(ST_NEXT)};
            OP_HLT: steps = {steps, int'(ST_HALT)};
            default: steps = {steps, int'(ST_NEXT)};
        endcase
    endtask

    // Queues the expected observations for one instruction; max_rec truncates
    // it, hold_extra adds frozen cycles after HALT. Returns the record count.
    task automatic push_instr(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] bus, input int max_rec, input int hold_extra,
                              output int n_rec);
        bit         jok;
        logic [7:0] e_alu;
        logic       e_cout;
        logic [3:0] st;
        logic [W-1:0] rec;
        int         a_i, b_i;
        a_i = int'(a);
        b_i = int'(b);
        opcode = op; rega = a; regb = b; bus_in = bus;
        build_steps(op);
        jok = (op == OP_JMP) || (op == OP_JEZ && a == 0) || (op == OP_JNZ && a != 0);
        if (op == OP_SUB) begin
            e_alu  = 8'((a_i - b_i + 256) % 256);
            e_cout = (a_i >= b_i);
        end else begin
            e_alu  = 8'((a_i + b_i) % 256);
            e_cout = (a_i + b_i) > 255;
        end
        n_rec = 0;
        for (int i = 0; i < steps.size() && n_rec < max_rec; i++) begin
            st  = 4'(steps[i]);
            rec = {st, 4'(i), pc_m, strobes_of(st, jok), e_alu, e_cout, (a == 8'h00)};
            exp_q.push_back(rec);
            n_rec++;
            if (st == ST_FETCH_INST || st == ST_LOAD_ADDR || st == ST_JUMP)
                pc_m = (st == ST_JUMP && jok) ? bus : pc_m + 8'd1;
            if (st == ST_HALT) begin
                for (int k = 0; k < hold_extra; k++) begin
                    exp_q.push_back(rec);
                    n_rec++;
                end
            end
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] bus);
        int n;
        push_instr(op, a, b, bus, 100, 0, n);
        wait_edges(n);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cycle"}, 64'(cycle), 64'd0);
        check({tag, "_pc"}, 64'(pc), 64'h00);
        check({tag, "_state"}, 64'(state), 64'(ST_FETCH_PC));
        check({tag, "_strobes"}, 64'({c_ai, c_bi, c_ii, c_mi, c_ao, c_co, c_eo, c_ro, c_ri, c_oi, c_halt}),
              64'(strobes_of(ST_FETCH_PC, 1'b0)));
    endtask

    // Asynchronous reset away from any clock edge; released just after a posedge.
    task automatic do_reset(input string tag);
        mon_en = 1'b0;
        check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        #2 reset = 1'b0;
        #1 check_reset_state({tag, "_async"});
        wait_edges(2);
        check_reset_state({tag, "_held"});
        reset = 1'b1;
        pc_m  = 8'h00;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL monitor_underflow @%0t: got no expectation for state %0d", $time, state);
            end else begin
                check("step", 64'(obs), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations left", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] op, a;
        #3 check_reset_state("por");
        @(posedge clk);
        #1 reset = 1'b1;
        mon_en = 1'b1;

        issue(OP_LDA, 8'h11, 8'h22, 8'h40);
        issue(OP_ADD, 8'hF0, 8'h20, 8'h00);
        issue(OP_SUB, 8'h05, 8'h07, 8'h00);
        issue(OP_JEZ, 8'h00, 8'h01, 8'h80);
        issue(OP_JEZ, 8'h03, 8'h01, 8'h80);
        issue(OP_JNZ, 8'h03, 8'h01, 8'hC4);
        issue(OP_JNZ, 8'h00, 8'h01, 8'h10);
        issue(8'hFF, 8'h09, 8'h09, 8'h55);
        issue(OP_OUT, 8'h7E, 8'h01, 8'h00);
        issue(OP_STA, 8'h7E, 8'h01, 8'h00);
        issue(OP_LDB, 8'h00, 8'hFF, 8'h00);
        issue(OP_JMP, 8'h01, 8'h01, 8'hFF);
        issue(OP_NOP, 8'h01, 8'h01, 8'h00);

        for (int i = 0; i < 60; i++) begin
            op = 8'($urandom_range(0, 15));
            if (op == OP_HLT) op = 8'hFF;
            a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            issue(op, a, 8'($urandom), 8'($urandom));
        end

        issue(OP_JMP, 8'h00, 8'h00, 8'h26);
        push_instr(OP_LDA, 8'h12, 8'h34, 8'h40, 4, 0, n);
        wait_edges(n - 1);
        @(negedge clk);
        #1;
        check("midrun_cycle", 64'(cycle), 64'd3);
        check("midrun_pc", 64'(pc), 64'h27);
        do_reset("midrun");

        issue(OP_JMP, 8'h00, 8'h00, 8'hFE);
        push_instr(OP_HLT, 8'h05, 8'h06, 8'h00, 100, 10, n);
        wait_edges(n);
        check("halt_cycle_frozen", 64'(cycle), 64'd2);
        check("halt_pc", 64'(pc), 64'hFF);
        do_reset("halt");
        issue(OP_ADD, 8'h01, 8'h02, 8'h00);

        mon_en = 1'b0;
        check("final_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
